// File: rtl/uncached_store_buffer_if.sv
// uncached_store_buffer_if: sram-like request/response bundle
// Signals: req/wr/size/addr/wdata go from master to slave.
//          rdata/addr_ok/data_ok go from slave to master.
// Modports: master is the requester side and slave is the responder side.
interface uncached_store_buffer_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        addr_ok;
  logic        data_ok;
  modport master (output req, wr, size, addr, wdata, input rdata, addr_ok, data_ok);
  modport slave  (input req, wr, size, addr, wdata, output rdata, addr_ok, data_ok);
endinterface

// File: rtl/uncached_store_buffer.sv
// uncached_store_buffer: posted-write buffer for uncached accesses ahead of the sram-to-AXI converter
// Ports: clk and resetn (asynchronous, active-low).
//        cpu is the slave sram-like port facing the CPU data side.
//        mem is the master sram-like port that drives the converter.
//        wbuf_empty is high when no store is buffered, pending or draining.
module uncached_store_buffer #(
  parameter int DEPTH = 4,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic                           clk,
  input  logic                           resetn,
  uncached_store_buffer_if.slave         cpu,
  uncached_store_buffer_if.master        mem,
  output logic                           wbuf_empty
);
  localparam int CW = PTR_W + 1;
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_WAIT, RD_REQ, RD_WAIT} state_t;
  state_t state, state_nxt;
  logic [1:0]  q_size  [DEPTH];
  logic [31:0] q_addr  [DEPTH];
  logic [31:0] q_wdata [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [CW-1:0] count, count_nxt;
  logic [1:0]  rd_size;
  logic [31:0] rd_addr;
  logic wr_ack, full, in_rd, push, pop, ld_ok;
  assign full  = count == CW'(DEPTH);
  assign in_rd = state == RD_REQ || state == RD_WAIT;
  // A full buffer refuses stores even when the head pops in the same cycle.
  assign push  = cpu.req & cpu.wr & !full & !in_rd;
  assign pop   = state == WR_WAIT && mem.data_ok;
  // Loads wait until every earlier store has both retired and drained.
  assign ld_ok = state == IDLE && count == '0 && !wr_ack && cpu.req && !cpu.wr;
  assign count_nxt = count + CW'(push) - CW'(pop);
  assign cpu.addr_ok = push | ld_ok;
  assign cpu.data_ok = wr_ack | (state == RD_WAIT && mem.data_ok);
  assign cpu.rdata   = mem.rdata;
  assign mem.req   = state == WR_REQ || state == RD_REQ;
  assign mem.wr    = state == WR_REQ || state == WR_WAIT;
  // The converter passes mem_* through combinationally, so they hold through WR_WAIT and RD_WAIT.
  assign mem.size  = in_rd ? rd_size : q_size[head];
  assign mem.addr  = in_rd ? rd_addr : q_addr[head];
  assign mem.wdata = q_wdata[head];
  assign wbuf_empty = count == '0 && state == IDLE && !wr_ack;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = count != '0 ? WR_REQ : ld_ok ? RD_REQ : IDLE;
      WR_REQ:  state_nxt = mem.addr_ok ? WR_WAIT : WR_REQ;
      WR_WAIT: state_nxt = !mem.data_ok ? WR_WAIT : count_nxt != '0 ? WR_REQ : IDLE;
      RD_REQ:  state_nxt = mem.addr_ok ? RD_WAIT : RD_REQ;
      RD_WAIT: state_nxt = mem.data_ok ? IDLE : RD_WAIT;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      count  <= '0;
      head   <= '0;
      tail   <= '0;
      wr_ack <= 1'b0;
    end else begin
      state  <= state_nxt;
      count  <= count_nxt;
      head   <= head + PTR_W'(pop);
      tail   <= tail + PTR_W'(push);
      wr_ack <= push;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      q_size[tail]  <= cpu.size;
      q_addr[tail]  <= cpu.addr;
      q_wdata[tail] <= cpu.wdata;
    end
    if (ld_ok) begin
      rd_size <= cpu.size;
      rd_addr <= cpu.addr;
    end
  end
endmodule

// File: tb/tb_uncached_store_buffer.sv
// tb_uncached_store_buffer: directed checks of store posting, draining, load ordering and reset
module tb_uncached_store_buffer;
  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic wbuf_empty;
  int n_vec = 0;
  int n_err = 0;
  uncached_store_buffer_if cpu_if ();
  uncached_store_buffer_if mem_if ();
  uncached_store_buffer dut (
    .clk(clk),
    .resetn(resetn),
    .cpu(cpu_if),
    .mem(mem_if),
    .wbuf_empty(wbuf_empty)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic cyc;
    @(negedge clk);
  endtask
  task automatic cpu_st(input logic [31:0] a, input logic [31:0] d);
    cpu_if.req = 1'b1; cpu_if.wr = 1'b1; cpu_if.size = 2'd2; cpu_if.addr = a; cpu_if.wdata = d;
  endtask
  task automatic cpu_ld(input logic [1:0] s, input logic [31:0] a);
    cpu_if.req = 1'b1; cpu_if.wr = 1'b0; cpu_if.size = s; cpu_if.addr = a; cpu_if.wdata = '0;
  endtask
  task automatic cpu_off;
    cpu_if.req = 1'b0; cpu_if.wr = 1'b0;
  endtask
  task automatic drain_one(input string tag, input logic [31:0] a, input logic [31:0] d);
    #1;
    chk({tag, "_req"}, 32'(mem_if.req), 32'd1);
    chk({tag, "_wr"}, 32'(mem_if.wr), 32'd1);
    chk({tag, "_addr"}, mem_if.addr, a);
    chk({tag, "_wdata"}, mem_if.wdata, d);
    mem_if.addr_ok = 1'b1;
    cyc();
    mem_if.addr_ok = 1'b0; mem_if.data_ok = 1'b1;
    #1;
    chk({tag, "_req_drop"}, 32'(mem_if.req), 32'd0);
    chk({tag, "_addr_hold"}, mem_if.addr, a);
    cyc();
    mem_if.data_ok = 1'b0;
  endtask
  initial begin
    cpu_off();
    cpu_if.size = '0; cpu_if.addr = '0; cpu_if.wdata = '0;
    mem_if.addr_ok = 1'b0; mem_if.data_ok = 1'b0; mem_if.rdata = '0;
    #2;
    chk("rst_empty", 32'(wbuf_empty), 32'd1);
    chk("rst_mem_req", 32'(mem_if.req), 32'd0);
    chk("rst_data_ok", 32'(cpu_if.data_ok), 32'd0);
    chk("rst_addr_ok", 32'(cpu_if.addr_ok), 32'd0);
    cyc();
    resetn = 1'b1;
    cyc();
    // single store
    cpu_st(32'h1FAF_0000, 32'h1234_5678);
    #1 chk("s1_addr_ok", 32'(cpu_if.addr_ok), 32'd1);
    cyc();
    cpu_off();
    #1 chk("s1_data_ok", 32'(cpu_if.data_ok), 32'd1);
    chk("s1_no_req_yet", 32'(mem_if.req), 32'd0);
    chk("s1_not_empty", 32'(wbuf_empty), 32'd0);
    cyc();
    #1 chk("s1_data_ok_once", 32'(cpu_if.data_ok), 32'd0);
    chk("s1_req", 32'(mem_if.req), 32'd1);
    chk("s1_wr", 32'(mem_if.wr), 32'd1);
    chk("s1_addr", mem_if.addr, 32'h1FAF_0000);
    chk("s1_wdata", mem_if.wdata, 32'h1234_5678);
    mem_if.addr_ok = 1'b1;
    cyc();
    mem_if.addr_ok = 1'b0;
    #1 chk("s1_req_drop", 32'(mem_if.req), 32'd0);
    chk("s1_wait_addr", mem_if.addr, 32'h1FAF_0000);
    cyc();
    #1 chk("s1_wait_empty", 32'(wbuf_empty), 32'd0);
    cyc();
    mem_if.data_ok = 1'b1;
    #1 chk("s1_no_cpu_ok", 32'(cpu_if.data_ok), 32'd0);
    cyc();
    mem_if.data_ok = 1'b0;
    #1 chk("s1_empty", 32'(wbuf_empty), 32'd1);
    chk("s1_idle_req", 32'(mem_if.req), 32'd0);
    cyc();
    // five back-to-back stores into a four-entry buffer
    for (int i = 0; i < 4; i++) begin
      cpu_st(32'h1FAF_1000 + 32'(4 * i), 32'hA000_0000 + 32'(i));
      #1 chk($sformatf("b2b_acc%0d", i), 32'(cpu_if.addr_ok), 32'd1);
      if (i > 0) chk($sformatf("b2b_dok%0d", i), 32'(cpu_if.data_ok), 32'd1);
      cyc();
    end
    cpu_st(32'h1FAF_1010, 32'hA000_0004);
    #1 chk("b2b_full", 32'(cpu_if.addr_ok), 32'd0);
    chk("b2b_dok3", 32'(cpu_if.data_ok), 32'd1);
    cyc();
    #1 chk("b2b_full2", 32'(cpu_if.addr_ok), 32'd0);
    chk("b2b_head", mem_if.addr, 32'h1FAF_1000);
    chk("b2b_req", 32'(mem_if.req), 32'd1);
    mem_if.addr_ok = 1'b1;
    cyc();
    mem_if.addr_ok = 1'b0; mem_if.data_ok = 1'b1;
    #1 chk("full_pop_rej", 32'(cpu_if.addr_ok), 32'd0);
    chk("b2b_a0_hold", mem_if.addr, 32'h1FAF_1000);
    chk("b2b_a0_data", mem_if.wdata, 32'hA000_0000);
    cyc();
    mem_if.data_ok = 1'b0;
    #1 chk("full_pop_acc", 32'(cpu_if.addr_ok), 32'd1);
    cyc();
    cpu_st(32'h1FAF_2222, 32'h0);
    #1 chk("refull", 32'(cpu_if.addr_ok), 32'd0);
    chk("a4_dok", 32'(cpu_if.data_ok), 32'd1);
    cpu_off();
    for (int i = 1; i < 5; i++)
      drain_one($sformatf("drain%0d", i), 32'h1FAF_1000 + 32'(4 * i), 32'hA000_0000 + 32'(i));
    #1 chk("b2b_empty", 32'(wbuf_empty), 32'd1);
    cyc();
    // store followed by a load
    cpu_st(32'h1FAF_F000, 32'h0BAD_F00D);
    #1 chk("sl_st_acc", 32'(cpu_if.addr_ok), 32'd1);
    cyc();
    cpu_ld(2'd2, 32'h1FAF_F004);
    #1 chk("sl_ld_hold1", 32'(cpu_if.addr_ok), 32'd0);
    cyc();
    #1 chk("sl_ld_hold2", 32'(cpu_if.addr_ok), 32'd0);
    chk("sl_st_addr", mem_if.addr, 32'h1FAF_F000);
    mem_if.addr_ok = 1'b1;
    cyc();
    mem_if.addr_ok = 1'b0; mem_if.data_ok = 1'b1;
    #1 chk("sl_ld_hold3", 32'(cpu_if.addr_ok), 32'd0);
    cyc();
    mem_if.data_ok = 1'b0;
    #1 chk("sl_ld_acc", 32'(cpu_if.addr_ok), 32'd1);
    cyc();
    cpu_off();
    #1 chk("sl_rd_req", 32'(mem_if.req), 32'd1);
    chk("sl_rd_wr", 32'(mem_if.wr), 32'd0);
    chk("sl_rd_addr", mem_if.addr, 32'h1FAF_F004);
    chk("sl_rd_size", 32'(mem_if.size), 32'd2);
    mem_if.addr_ok = 1'b1;
    cyc();
    mem_if.addr_ok = 1'b0; mem_if.data_ok = 1'b1; mem_if.rdata = 32'hCAFE_BABE;
    #1 chk("sl_rd_dok", 32'(cpu_if.data_ok), 32'd1);
    chk("sl_rdata", cpu_if.rdata, 32'hCAFE_BABE);
    chk("sl_rd_req_drop", 32'(mem_if.req), 32'd0);
    cyc();
    mem_if.data_ok = 1'b0;
    #1 chk("sl_empty", 32'(wbuf_empty), 32'd1);
    chk("sl_dok_clear", 32'(cpu_if.data_ok), 32'd0);
    cyc();
    // load with empty buffer, stores blocked during the read
    cpu_ld(2'd0, 32'h1FAF_2001);
    #1 chk("ld_acc", 32'(cpu_if.addr_ok), 32'd1);
    cyc();
    cpu_st(32'h1FAF_3000, 32'h7777_0001);
    #1 chk("ld_st_blk0", 32'(cpu_if.addr_ok), 32'd0);
    chk("ld_req", 32'(mem_if.req), 32'd1);
    chk("ld_addr", mem_if.addr, 32'h1FAF_2001);
    chk("ld_size", 32'(mem_if.size), 32'd0);
    mem_if.addr_ok = 1'b1;
    cyc();
    mem_if.addr_ok = 1'b0;
    for (int i = 1; i < 3; i++) begin
      #1 chk($sformatf("ld_st_blk%0d", i), 32'(cpu_if.addr_ok), 32'd0);
      cyc();
    end
    mem_if.data_ok = 1'b1; mem_if.rdata = 32'h55AA_1234;
    #1 chk("ld_dok", 32'(cpu_if.data_ok), 32'd1);
    chk("ld_rdata", cpu_if.rdata, 32'h55AA_1234);
    chk("ld_st_blk3", 32'(cpu_if.addr_ok), 32'd0);
    cyc();
    mem_if.data_ok = 1'b0;
    #1 chk("ld_st_acc", 32'(cpu_if.addr_ok), 32'd1);
    cyc();
    cpu_off();
    #1 chk("ld_st_dok", 32'(cpu_if.data_ok), 32'd1);
    cyc();
    drain_one("ld_drain", 32'h1FAF_3000, 32'h7777_0001);
    #1 chk("ld_empty", 32'(wbuf_empty), 32'd1);
    cyc();
    // reset in WR_WAIT with three entries buffered
    for (int i = 0; i < 3; i++) begin
      cpu_st(32'h1FAF_4000 + 32'(4 * i), 32'hB000_0000 + 32'(i));
      cyc();
    end
    cpu_off();
    mem_if.addr_ok = 1'b1;
    cyc();
    mem_if.addr_ok = 1'b0;
    #1 chk("rw_wait_wr", 32'(mem_if.wr), 32'd1);
    chk("rw_not_empty", 32'(wbuf_empty), 32'd0);
    #1 resetn = 1'b0;
    #1 chk("rw_req", 32'(mem_if.req), 32'd0);
    chk("rw_wr", 32'(mem_if.wr), 32'd0);
    chk("rw_empty", 32'(wbuf_empty), 32'd1);
    chk("rw_dok", 32'(cpu_if.data_ok), 32'd0);
    cyc();
    cyc();
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      #1 chk($sformatf("rw_quiet%0d", i), 32'(mem_if.req), 32'd0);
      chk($sformatf("rw_idle%0d", i), 32'(wbuf_empty), 32'd1);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
